sram_axi_slave: RTL and testbench
=================================

SRAM_AXI_SLAVE -- requirements
Module: sram_axi_slave

Interface
REQ-001 SHALL have parameter SRAM_ADDR_BITS, default 14, meaning SRAM word-address width (64 KiB of 32-bit words).
REQ-002 SHALL have parameter BASE_LSB, default 2, meaning the AXI address bit that maps to SRAM word-address bit 0.
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports listed first:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous active-high reset.
REQ-004 SHALL provide an AXI write-address slave port: AWID in 8, AWADDR in 32, AWLEN in 4, AWSIZE in 3, AWBURST in 2, AWVALID in 1, AWREADY out 1.
REQ-005 SHALL provide an AXI write-data slave port: WDATA in 32, WSTRB in 4, WLAST in 1, WVALID in 1, WREADY out 1.
REQ-006 SHALL provide an AXI write-response slave port: BID out 8, BRESP out 2, BVALID out 1, BREADY in 1.
REQ-007 SHALL provide an AXI read-address slave port: ARID in 8, ARADDR in 32, ARLEN in 4, ARSIZE in 3, ARBURST in 2, ARVALID in 1, ARREADY out 1.
REQ-008 SHALL provide an AXI read-data slave port: RID out 8, RDATA out 32, RRESP out 2, RLAST out 1, RVALID out 1, RREADY in 1.
REQ-009 SHALL provide an SRAM port with these signals:
- sram_ceb  out  1  active-low chip enable.
- sram_web  out  1  active-low write enable.
- sram_bweb  out  32  active-low bit write enable.
- sram_a  out  SRAM_ADDR_BITS  word address.
- sram_di  out  32  write data.
- sram_do  in  32  read data, valid one cycle after a read enable.

Function
REQ-010 SHALL implement FSM states IDLE, R_REQ, R_DATA, W_DATA and B_RESP.
REQ-011 In IDLE, AWREADY and ARREADY SHALL both be 1; if AWVALID and ARVALID arrive in the same cycle, write wins and ARREADY SHALL be 0 in that cycle.
REQ-012 On AR handshake, the block SHALL latch ARID, word address and ARLEN, clear the beat counter, and go to R_REQ.
REQ-013 In R_REQ, the block SHALL drive sram_ceb=0, sram_web=1 and sram_a=current address, then go to R_DATA.
REQ-014 On entry to R_DATA, the block SHALL register sram_do into RDATA.
- RVALID=1 throughout R_DATA.
- RDATA, RID, RLAST and RRESP SHALL stay stable while RREADY=0.
- RLAST=1 iff beat counter equals the latched len.
REQ-015 On R handshake in R_DATA:
- If not last, the block SHALL increment address and counter and go to R_REQ (2 cycles per beat; first RVALID 2 cycles after the AR handshake).
- If last, the block SHALL go to IDLE.
REQ-016 On AW handshake, the block SHALL latch AWID, word address and AWLEN and go to W_DATA; WREADY SHALL be 1 only in W_DATA.
REQ-017 On each W handshake, the block SHALL write in the same cycle: sram_ceb=0, sram_web=0, sram_di=WDATA, sram_a=current address, and sram_bweb byte k = ~{8{WSTRB[k]}}. The address SHALL then increment.
- A beat with WSTRB=0 SHALL still consume an address and leave memory unchanged.
REQ-018 The write burst SHALL end on the handshake with WLAST=1, regardless of the beat count, and the FSM SHALL go to B_RESP; the beat counter wraps modulo 16.
REQ-019 In B_RESP, BVALID SHALL be 1, with BID=latched ID and BRESP=OKAY (2'b00); on BREADY the FSM SHALL go to IDLE.
REQ-020 Word-address increment SHALL wrap from all-ones to 0; address bits outside [BASE_LSB+SRAM_ADDR_BITS-1:BASE_LSB] SHALL be ignored.
REQ-021 Outside REQ-013 and REQ-017, sram_ceb and sram_web SHALL be 1 and sram_bweb all-ones.

Reset
REQ-022 While ARESET=1 at a clock edge, the FSM SHALL return to IDLE, abandoning any burst in progress, with no SRAM write in that cycle.
REQ-023 Reset values SHALL be:
- AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST: 0.
- BID, RID, RDATA, BRESP, RRESP: 0.
- sram_ceb, sram_web: 1; sram_bweb: all-ones.
REQ-024 Ready outputs SHALL assert no earlier than the first edge after ARESET deasserts.

Configuration
REQ-025 Macro SRAM_AXI_SLAVE_SLVERR_EN SHALL control burst and size checking:
- Defined: a burst with BURST != INCR or SIZE != 3'b010 SHALL complete its full handshake but suppress every SRAM access, return RDATA=0, and use RRESP/BRESP=SLVERR (2'b10).
- Undefined: every burst SHALL be treated as INCR, 32-bit, with an OKAY response.

Structure
REQ-026 Package sram_axi_slave_pkg SHALL hold the state enum, the RESP_OKAY and RESP_SLVERR constants, and the BURST_INCR and SIZE_WORD constants.
REQ-027 No sub-module SHALL be used: a single FSM plus datapath, with the SRAM macro instantiated by the parent.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Single write, AWADDR=0x0000_0010, WDATA=0xDEADBEEF, WSTRB=4'b0011 -> sram_a=4, sram_bweb=0xFFFF0000; BVALID with BRESP=0 and BID=AWID.
- Read burst, ARLEN=3 from 0x20 with RREADY held 1 -> sram_a 8,9,10,11; 4 RVALID beats; RLAST only on the 4th; RID=ARID.
- RREADY held 0 for 5 cycles on beat 2 -> RDATA/RLAST stable, with no extra SRAM read.
- AWVALID and ARVALID in the same IDLE cycle -> AW accepted, ARREADY=0; the read is served after BVALID/BREADY.
- ARESET pulsed mid write burst after beat 1 -> outputs at reset values next cycle; the next AW is accepted normally.
- With SRAM_AXI_SLAVE_SLVERR_EN defined, ARBURST=2'b10 -> no sram_ceb=0 cycle, RRESP=2'b10, RDATA=0.

Source files
------------

// File: rtl/sram_axi_slave_pkg.sv
// Shared types and constants for sram_axi_slave.
//   state_e           : controller FSM states (idle, read request, read data, write data,
//                       write response)
//   RESP_*            : AXI response codes
//   BURST_INCR        : the only burst type the SRAM datapath walks
//   SIZE_WORD         : the only transfer size the 32-bit SRAM supports
//   burst_unsupported : flags a burst the datapath cannot serve
package sram_axi_slave_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRReq,
    StRData,
    StWData,
    StBResp
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_WORD   = 3'b010;

  function automatic logic burst_unsupported(input logic [1:0] burst, input logic [2:0] size);
    return (burst != BURST_INCR) || (size != SIZE_WORD);
  endfunction

endpackage

// File: rtl/sram_axi_slave.sv
// AXI3-style slave that serves INCR bursts from a single-port synchronous SRAM.
// One transaction at a time; a write address wins over a read address in the same cycle.
// Read beats take two cycles (SRAM request, then data); write beats go to the SRAM in the
// cycle of the W handshake.
//
// Ports:
//   ACLK, ARESET             : clock, synchronous active-high reset
//   AW*/W*/B*                : write address / data / response channels
//   AR*/R*                   : read address / data channels
//   sram_ceb, sram_web       : active-low chip / write enable
//   sram_bweb                : active-low bit write enable
//   sram_a, sram_di, sram_do : word address, write data, read data (one cycle latency)
//
// Build option: define SRAM_AXI_SLAVE_SLVERR_EN to answer non-INCR or non-32-bit bursts
// with SLVERR; such bursts still complete every handshake but never touch the SRAM and
// return zero read data. Without it every burst is treated as INCR, 32-bit, OKAY.
module sram_axi_slave
  import sram_axi_slave_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_BITS = 14,
  parameter int unsigned BASE_LSB       = 2
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [7:0]                AWID,
  input  logic [31:0]               AWADDR,
  input  logic [3:0]                AWLEN,
  input  logic [2:0]                AWSIZE,
  input  logic [1:0]                AWBURST,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [31:0]               WDATA,
  input  logic [3:0]                WSTRB,
  input  logic                      WLAST,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [7:0]                BID,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [7:0]                ARID,
  input  logic [31:0]               ARADDR,
  input  logic [3:0]                ARLEN,
  input  logic [2:0]                ARSIZE,
  input  logic [1:0]                ARBURST,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [7:0]                RID,
  output logic [31:0]               RDATA,
  output logic [1:0]                RRESP,
  output logic                      RLAST,
  output logic                      RVALID,
  input  logic                      RREADY,
  output logic                      sram_ceb,
  output logic                      sram_web,
  output logic [31:0]               sram_bweb,
  output logic [SRAM_ADDR_BITS-1:0] sram_a,
  output logic [31:0]               sram_di,
  input  logic [31:0]               sram_do
);

  state_e                    state_q, state_d;
  logic                      init_q, init_d;    // readies stay low until one edge after reset
  logic [7:0]                id_q, id_d;
  logic [SRAM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [3:0]                len_q, len_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      err_q, err_d;
  logic                      fresh_q, fresh_d;  // first R_DATA cycle: sram_do is live
  logic [31:0]               rdata_q, rdata_d;

  logic        idle_rdy;
  logic        aw_hs, ar_hs, w_hs;
  logic        aw_err, ar_err;
  logic [31:0] rdata_mux;
  logic        unused_ok;

`ifdef SRAM_AXI_SLAVE_SLVERR_EN
  assign aw_err    = burst_unsupported(AWBURST, AWSIZE);
  assign ar_err    = burst_unsupported(ARBURST, ARSIZE);
  assign unused_ok = ^{AWADDR, ARADDR};
`else
  assign aw_err    = 1'b0;
  assign ar_err    = 1'b0;
  assign unused_ok = ^{AWADDR, ARADDR, AWSIZE, AWBURST, ARSIZE, ARBURST};
`endif

  // Channel handshakes and outputs
  assign idle_rdy = init_q & ~ARESET & (state_q == StIdle);
  assign AWREADY  = idle_rdy;
  assign ARREADY  = idle_rdy & ~AWVALID;
  assign WREADY   = ~ARESET & (state_q == StWData);
  assign aw_hs    = AWVALID & AWREADY;
  assign ar_hs    = ARVALID & ARREADY;
  assign w_hs     = WVALID & WREADY;

  assign BVALID = (state_q == StBResp);
  assign BID    = id_q;
  assign BRESP  = (BVALID && err_q) ? RESP_SLVERR : RESP_OKAY;

  // Capture sram_do while it is live, then hold it so a stalled beat stays stable.
  assign rdata_mux = fresh_q ? (err_q ? 32'h0 : sram_do) : rdata_q;
  assign RVALID    = (state_q == StRData);
  assign RID       = id_q;
  assign RDATA     = rdata_mux;
  assign RLAST     = RVALID & (cnt_q == len_q);
  assign RRESP     = (RVALID && err_q) ? RESP_SLVERR : RESP_OKAY;

  // SRAM drive: idle-high unless reading in R_REQ or writing on a W handshake.
  assign sram_a = addr_q;

  always_comb begin
    sram_ceb  = 1'b1;
    sram_web  = 1'b1;
    sram_bweb = '1;
    sram_di   = '0;
    if (!ARESET && !err_q) begin
      if (state_q == StRReq) begin
        sram_ceb = 1'b0;
      end else if (w_hs) begin
        sram_ceb = 1'b0;
        sram_web = 1'b0;
        sram_di  = WDATA;
        for (int k = 0; k < 4; k++) begin
          sram_bweb[8*k +: 8] = {8{~WSTRB[k]}};
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    init_d  = 1'b1;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fresh_d = 1'b0;
    rdata_d = fresh_q ? rdata_mux : rdata_q;

    unique case (state_q)
      StIdle: begin
        if (aw_hs) begin
          id_d    = AWID;
          addr_d  = AWADDR[BASE_LSB +: SRAM_ADDR_BITS];
          len_d   = AWLEN;
          cnt_d   = 4'd0;
          err_d   = aw_err;
          state_d = StWData;
        end else if (ar_hs) begin
          id_d    = ARID;
          addr_d  = ARADDR[BASE_LSB +: SRAM_ADDR_BITS];
          len_d   = ARLEN;
          cnt_d   = 4'd0;
          err_d   = ar_err;
          state_d = StRReq;
        end
      end
      StRReq: begin
        fresh_d = 1'b1;
        state_d = StRData;
      end
      StRData: begin
        if (RREADY) begin
          if (RLAST) begin
            state_d = StIdle;
          end else begin
            addr_d  = addr_q + SRAM_ADDR_BITS'(1);
            cnt_d   = cnt_q + 4'd1;
            state_d = StRReq;
          end
        end
      end
      StWData: begin
        if (w_hs) begin
          addr_d = addr_q + SRAM_ADDR_BITS'(1);
          cnt_d  = cnt_q + 4'd1;
          // WLAST alone ends the burst; the beat count is not compared with AWLEN.
          if (WLAST) state_d = StBResp;
        end
      end
      StBResp: begin
        if (BREADY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= StIdle;
      init_q  <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      fresh_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fresh_q <= fresh_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_axi_slave.sv
// Directed bench for sram_axi_slave with a behavioural single-port SRAM attached.
module tb_sram_axi_slave;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [7:0]  AWID = '0;
  logic [31:0] AWADDR = '0;
  logic [3:0]  AWLEN = '0;
  logic [2:0]  AWSIZE = 3'b010;
  logic [1:0]  AWBURST = 2'b01;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WLAST = 1'b0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [7:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [7:0]  ARID = '0;
  logic [31:0] ARADDR = '0;
  logic [3:0]  ARLEN = '0;
  logic [2:0]  ARSIZE = 3'b010;
  logic [1:0]  ARBURST = 2'b01;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [7:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY = 1'b0;
  logic        sram_ceb, sram_web;
  logic [31:0] sram_bweb, sram_di;
  logic [13:0] sram_a;
  logic [31:0] sram_do = '0;

  always #5 ACLK = ~ACLK;

  sram_axi_slave #(
    .SRAM_ADDR_BITS(14),
    .BASE_LSB      (2)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_bweb(sram_bweb), .sram_a(sram_a),
    .sram_di(sram_di), .sram_do(sram_do)
  );

  // Behavioural SRAM: synchronous, read data valid the cycle after the request.
  logic [31:0] mem [0:16383];
  int          rd_cnt = 0;
  int          wr_cnt = 0;

  always @(posedge ACLK) begin
    if (!sram_ceb) begin
      if (!sram_web) begin
        mem[sram_a] <= (mem[sram_a] & sram_bweb) | (sram_di & ~sram_bweb);
        wr_cnt      <= wr_cnt + 1;
      end else begin
        sram_do <= mem[sram_a];
        rd_cnt  <= rd_cnt + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " AWREADY"}, AWREADY, 0);
    chk({tag, " ARREADY"}, ARREADY, 0);
    chk({tag, " WREADY"}, WREADY, 0);
    chk({tag, " BVALID"}, BVALID, 0);
    chk({tag, " RVALID"}, RVALID, 0);
    chk({tag, " RLAST"}, RLAST, 0);
    chk({tag, " BID"}, BID, 0);
    chk({tag, " RID"}, RID, 0);
    chk({tag, " RDATA"}, RDATA, 0);
    chk({tag, " BRESP"}, BRESP, 0);
    chk({tag, " RRESP"}, RRESP, 0);
    chk({tag, " sram_ceb"}, sram_ceb, 1);
    chk({tag, " sram_web"}, sram_web, 1);
    chk({tag, " sram_bweb"}, sram_bweb, 32'hFFFF_FFFF);
  endtask

  // Single-beat write; exp_ceb=1 means the SRAM must not be touched.
  task automatic write_single(input logic [31:0] addr, input logic [7:0] id,
                              input logic [2:0] size, input logic [31:0] data,
                              input logic [3:0] strb, input logic exp_ceb,
                              input logic [13:0] exp_a, input logic [31:0] exp_bweb,
                              input logic [1:0] exp_bresp, input string tag);
    @(negedge ACLK);
    AWADDR = addr; AWID = id; AWLEN = 4'd0; AWSIZE = size; AWBURST = 2'b01; AWVALID = 1'b1;
    #1;
    for (int n = 0; n < 20 && !AWREADY; n++) begin
      @(negedge ACLK);
      #1;
    end
    chk({tag, " AWREADY"}, AWREADY, 1);
    @(negedge ACLK);
    AWVALID = 1'b0; WDATA = data; WSTRB = strb; WLAST = 1'b1; WVALID = 1'b1;
    #1;
    chk({tag, " WREADY"}, WREADY, 1);
    chk({tag, " w sram_ceb"}, sram_ceb, exp_ceb);
    chk({tag, " w sram_web"}, sram_web, exp_ceb);
    chk({tag, " w sram_a"}, sram_a, exp_a);
    chk({tag, " w sram_bweb"}, sram_bweb, exp_bweb);
    @(negedge ACLK);
    WVALID = 1'b0; WLAST = 1'b0;
    #1;
    chk({tag, " BVALID"}, BVALID, 1);
    chk({tag, " BRESP"}, BRESP, exp_bresp);
    chk({tag, " BID"}, BID, id);
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
  endtask

  task automatic read_single(input logic [31:0] addr, input logic [7:0] id,
                             input logic [1:0] burst, input logic exp_ceb,
                             input logic [13:0] exp_a, input logic [31:0] exp_rd,
                             input logic [1:0] exp_rresp, input string tag);
    @(negedge ACLK);
    ARADDR = addr; ARID = id; ARLEN = 4'd0; ARSIZE = 3'b010; ARBURST = burst; ARVALID = 1'b1;
    #1;
    for (int n = 0; n < 20 && !ARREADY; n++) begin
      @(negedge ACLK);
      #1;
    end
    chk({tag, " ARREADY"}, ARREADY, 1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    #1;
    chk({tag, " r sram_ceb"}, sram_ceb, exp_ceb);
    chk({tag, " r sram_a"}, sram_a, exp_a);
    @(negedge ACLK);
    #1;
    chk({tag, " RVALID"}, RVALID, 1);
    chk({tag, " RDATA"}, RDATA, exp_rd);
    chk({tag, " RRESP"}, RRESP, exp_rresp);
    chk({tag, " RLAST"}, RLAST, 1);
    chk({tag, " RID"}, RID, id);
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    #1;
    chk({tag, " RVALID low"}, RVALID, 0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  id;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [13:0] exp_a;
    logic [31:0] exp_bweb;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    vecs[0] = '{32'h0000_0010, 8'h5A, 32'hDEAD_BEEF, 4'b0011, 14'd4, 32'hFFFF_0000,
                32'h0000_BEEF};
    vecs[1] = '{32'h0000_0010, 8'h11, 32'h1234_5678, 4'b1100, 14'd4, 32'h0000_FFFF,
                32'h1234_BEEF};
    vecs[2] = '{32'h0000_0040, 8'h22, 32'hCAFE_F00D, 4'b1111, 14'h10, 32'h0000_0000,
                32'hCAFE_F00D};
    vecs[3] = '{32'h0000_0040, 8'h33, 32'hFFFF_FFFF, 4'b0000, 14'h10, 32'hFFFF_FFFF,
                32'hCAFE_F00D};
    vecs[4] = '{32'hFFFF_FFFC, 8'h44, 32'hA5A5_5A5A, 4'b1111, 14'h3FFF, 32'h0000_0000,
                32'hA5A5_5A5A};
    vecs[5] = '{32'h0001_0008, 8'h55, 32'h0077_0000, 4'b0100, 14'd2, 32'hFF00_FFFF,
                32'h0077_0000};

    for (int i = 0; i < 16384; i++) mem[i] <= '0;
    for (int i = 0; i < 4; i++) mem[8 + i] <= 32'hB0B0_0000 + i;

    // Reset values, and readies held low until one edge after release.
    repeat (3) @(negedge ACLK);
    chk_reset("rst");
    ARESET = 1'b0;
    #1;
    chk("rst release AWREADY", AWREADY, 0);
    @(negedge ACLK);
    #1;
    chk("post rst AWREADY", AWREADY, 1);
    chk("post rst ARREADY", ARREADY, 1);

    // Single-beat write then read-back for each vector.
    foreach (vecs[i]) begin
      write_single(vecs[i].addr, vecs[i].id, 3'b010, vecs[i].data, vecs[i].strb, 1'b0,
                   vecs[i].exp_a, vecs[i].exp_bweb, 2'b00, $sformatf("vec%0d", i));
      read_single(vecs[i].addr, vecs[i].id + 8'd1, 2'b01, 1'b0, vecs[i].exp_a,
                  vecs[i].exp_rd, 2'b00, $sformatf("vec%0d rd", i));
    end

    // Read burst of 4 from 0x20 with RREADY held high.
    c0 = rd_cnt;
    @(negedge ACLK);
    ARADDR = 32'h20; ARID = 8'h3C; ARLEN = 4'd3; ARBURST = 2'b01; ARVALID = 1'b1;
    RREADY = 1'b1;
    #1;
    chk("burst ARREADY", ARREADY, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      ARVALID = 1'b0;
      #1;
      chk($sformatf("burst b%0d ceb", i), sram_ceb, 0);
      chk($sformatf("burst b%0d sram_a", i), sram_a, 8 + i);
      chk($sformatf("burst b%0d RVALID in req", i), RVALID, 0);
      @(negedge ACLK);
      #1;
      chk($sformatf("burst b%0d RVALID", i), RVALID, 1);
      chk($sformatf("burst b%0d RDATA", i), RDATA, 32'hB0B0_0000 + i);
      chk($sformatf("burst b%0d RLAST", i), RLAST, (i == 3) ? 1 : 0);
      chk($sformatf("burst b%0d RID", i), RID, 8'h3C);
    end
    @(negedge ACLK);
    RREADY = 1'b0;
    #1;
    chk("burst end RVALID", RVALID, 0);
    chk("burst read count", rd_cnt - c0, 4);

    // Stall beat 2 of a 3-beat read.
    c0 = rd_cnt;
    @(negedge ACLK);
    ARADDR = 32'h20; ARID = 8'h21; ARLEN = 4'd2; ARVALID = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0;
    @(negedge ACLK);
    #1;
    chk("stall b0 RDATA", RDATA, 32'hB0B0_0000);
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    @(negedge ACLK);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("stall c%0d RVALID", i), RVALID, 1);
      chk($sformatf("stall c%0d RDATA", i), RDATA, 32'hB0B0_0001);
      chk($sformatf("stall c%0d RLAST", i), RLAST, 0);
      chk($sformatf("stall c%0d ceb", i), sram_ceb, 1);
      @(negedge ACLK);
    end
    chk("stall read count", rd_cnt - c0, 2);
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    @(negedge ACLK);
    #1;
    chk("stall b2 RDATA", RDATA, 32'hB0B0_0002);
    chk("stall b2 RLAST", RLAST, 1);
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    chk("stall total reads", rd_cnt - c0, 3);

    // AW and AR together: write first, read waits for the B handshake.
    @(negedge ACLK);
    AWADDR = 32'hC0; AWID = 8'h42; AWLEN = 4'd0; AWVALID = 1'b1;
    ARADDR = 32'hC0; ARID = 8'h43; ARLEN = 4'd0; ARVALID = 1'b1;
    #1;
    chk("coll AWREADY", AWREADY, 1);
    chk("coll ARREADY", ARREADY, 0);
    @(negedge ACLK);
    AWVALID = 1'b0; WDATA = 32'h0BAD_F00D; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
    #1;
    chk("coll W ARREADY", ARREADY, 0);
    chk("coll W web", sram_web, 0);
    @(negedge ACLK);
    WVALID = 1'b0; WLAST = 1'b0;
    #1;
    chk("coll BVALID", BVALID, 1);
    chk("coll BID", BID, 8'h42);
    chk("coll B ARREADY", ARREADY, 0);
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    #1;
    chk("coll idle ARREADY", ARREADY, 1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    #1;
    chk("coll r ceb", sram_ceb, 0);
    chk("coll r sram_a", sram_a, 14'h30);
    @(negedge ACLK);
    #1;
    chk("coll RDATA", RDATA, 32'h0BAD_F00D);
    chk("coll RID", RID, 8'h43);
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;

    // Two-beat write at the top word: address wraps, WLAST ends it despite AWLEN=0.
    @(negedge ACLK);
    AWADDR = 32'h0000_FFFC; AWID = 8'h66; AWLEN = 4'd0; AWVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0; WDATA = 32'h1111_0001; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
    #1;
    chk("wrap b0 sram_a", sram_a, 14'h3FFF);
    @(negedge ACLK);
    WDATA = 32'h1111_0002; WLAST = 1'b1;
    #1;
    chk("wrap b1 sram_a", sram_a, 14'h0000);
    chk("wrap b1 WREADY", WREADY, 1);
    @(negedge ACLK);
    WVALID = 1'b0; WLAST = 1'b0;
    #1;
    chk("wrap BVALID", BVALID, 1);
    chk("wrap mem[0]", mem[0], 32'h1111_0002);
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;

    // Reset in the middle of a write burst.
    c0 = wr_cnt;
    @(negedge ACLK);
    AWADDR = 32'h100; AWID = 8'h77; AWLEN = 4'd3; AWVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0; WDATA = 32'h1111_2222; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
    @(negedge ACLK);
    WDATA = 32'h3333_4444; ARESET = 1'b1;
    #1;
    chk("mid rst ceb", sram_ceb, 1);
    chk("mid rst WREADY", WREADY, 0);
    @(negedge ACLK);
    ARESET = 1'b0; WVALID = 1'b0;
    #1;
    chk_reset("mid rst");
    chk("mid rst writes", wr_cnt - c0, 1);
    chk("mid rst mem[64]", mem[64], 32'h1111_2222);
    chk("mid rst mem[65]", mem[65], 32'h0);
    write_single(32'h200, 8'h78, 3'b010, 32'h5555_6666, 4'hF, 1'b0, 14'd128, 32'h0, 2'b00,
                 "after rst");
    chk("after rst mem[128]", mem[128], 32'h5555_6666);

`ifdef SRAM_AXI_SLAVE_SLVERR_EN
    c0 = rd_cnt + wr_cnt;
    read_single(32'h20, 8'h90, 2'b10, 1'b1, 14'd8, 32'h0, 2'b10, "slverr rd");
    write_single(32'h300, 8'h91, 3'b000, 32'h7777_8888, 4'hF, 1'b1, 14'd192, 32'hFFFF_FFFF,
                 2'b10, "slverr wr");
    chk("slverr accesses", rd_cnt + wr_cnt - c0, 0);
    chk("slverr mem[192]", mem[192], 32'h0);
`else
    read_single(32'h20, 8'h90, 2'b10, 1'b0, 14'd8, 32'hB0B0_0000, 2'b00, "wrap-burst rd");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
